// File: rtl/teclado_scan_ctrl.sv
// teclado_scan_ctrl: 4x4 keypad row scanner with debounce and ack handshake.
// Rows are driven one-hot (row r -> 4'b1000 >> r), columns are sensed
// active-high through a 2-flop synchronizer. An accepted key is reported as
// key_code = {row, c}, where c = 0 is col[3] and c = 3 is col[0]. It is held
// on key_valid until key_ack is sampled.
// Optional feature: define TECLADO_REPEAT_EN for auto-repeat while a key is held.
module teclado_scan_ctrl #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 8,
  parameter int REPEAT_CYC   = 32
) (
  input  logic       clk_sec,
  input  logic       rst_n,
  input  logic [3:0] col,
  input  logic       key_ack,
  output logic [3:0] ent_teclado,
  output logic [3:0] key_code,
  output logic       key_valid
);

  // Parameter legality is checked at elaboration time.
  if (SCAN_DIV < 2 || SCAN_DIV > 255 || DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 255 ||
      REPEAT_CYC < 1 || REPEAT_CYC > 65535) begin : g_param_err
    $error("teclado_scan_ctrl: parameter out of range");
  end

  localparam logic [7:0] SCAN_LAST = 8'(SCAN_DIV - 1);
  localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, VALID, RELEASE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  sync1_q, scol_q;
  logic [1:0]  row_q, row_d;
  logic [1:0]  c_q, c_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  ent_q, ent_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic [1:0]  c_pri;
  logic        key_bit;
`ifdef TECLADO_REPEAT_EN
  localparam logic [15:0] REP_LAST = 16'(REPEAT_CYC - 1);
  logic [15:0] rep_q, rep_d;
`endif

  assign ent_teclado = ent_q;
  assign key_code    = code_q;
  assign key_valid   = valid_q;

  // Synchronized level of the captured column (c = 0 maps to scol[3]).
  assign key_bit = scol_q[~c_q];

  // Column priority: col[3] wins, so the highest set scol bit gives the lowest c.
  always_comb begin
    c_pri = 2'd3;
    casez (scol_q)
      4'b1???: c_pri = 2'd0;
      4'b01??: c_pri = 2'd1;
      4'b001?: c_pri = 2'd2;
      default: c_pri = 2'd3;
    endcase
  end

  // Next-state and registered-output logic for the scan/debounce/ack FSM.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = valid_q;
`ifdef TECLADO_REPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = 8'd0;
          if (scol_q == 4'h0) begin
            row_d = row_q + 2'd1;
          end else begin
            c_d     = c_pri;
            state_d = DEBOUNCE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DEBOUNCE: begin
        if (!key_bit) begin
          // Bounce: abandon the candidate and rescan the same row from scratch.
          cnt_d   = 8'd0;
          state_d = SCAN;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = 8'd0;
          code_d  = {row_q, c_q};
          valid_d = 1'b1;
          state_d = VALID;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      VALID: begin
        // Only an acknowledge retires the event; a release here is ignored.
        if (key_ack) begin
          valid_d = 1'b0;
          cnt_d   = 8'd0;
          state_d = RELEASE;
`ifdef TECLADO_REPEAT_EN
          rep_d   = 16'd0;
`endif
        end
      end
      RELEASE: begin
        if (!key_bit) begin
`ifdef TECLADO_REPEAT_EN
          rep_d = 16'd0;
`endif
          if (cnt_q == DEB_LAST) begin
            cnt_d   = 8'd0;
            row_d   = row_q + 2'd1;
            state_d = SCAN;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          cnt_d = 8'd0;
`ifdef TECLADO_REPEAT_EN
          if (rep_q == REP_LAST) begin
            rep_d   = 16'd0;
            valid_d = 1'b1;
            state_d = VALID;
          end else begin
            rep_d = rep_q + 16'd1;
          end
`endif
        end
      end
      default: state_d = SCAN;
    endcase
    ent_d = 4'b1000 >> row_d;
  end

  // State, synchronizer and output registers.
  always_ff @(posedge clk_sec or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
      sync1_q <= 4'h0;
      scol_q  <= 4'h0;
      row_q   <= 2'd0;
      c_q     <= 2'd0;
      cnt_q   <= 8'd0;
      ent_q   <= 4'b1000;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
`ifdef TECLADO_REPEAT_EN
      rep_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= col;
      scol_q  <= sync1_q;
      row_q   <= row_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      ent_q   <= ent_d;
      code_q  <= code_d;
      valid_q <= valid_d;
`ifdef TECLADO_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

endmodule

// File: tb/tb_teclado_scan_ctrl.sv
// Directed bench for teclado_scan_ctrl (SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_CYC=32).
// A small keypad model closes one key: the pressed row's mask appears on col
// only while that row is driven. Outputs are sampled on the falling edge.
module tb_teclado_scan_ctrl;

  logic       clk_sec = 1'b0;
  logic       rst_n   = 1'b0;
  logic       key_ack = 1'b0;
  logic [3:0] col;
  logic [3:0] ent_teclado, key_code;
  logic       key_valid;

  logic       use_model = 1'b0;
  logic [1:0] pr = 2'd0;
  logic [1:0] pbit;
  logic [3:0] pm = 4'h0;
  logic [3:0] col_drv = 4'h0;
  logic [3:0] one_hot0 = 4'b1000;

  int checks = 0;
  int errors = 0;
  int n, ev;
  logic [3:0] row_ent;

  typedef struct {
    logic [1:0] row;
    logic [3:0] mask;
    logic [3:0] code;
  } vec_t;
  vec_t vecs[6];

  assign pbit = 2'd3 - pr;
  assign col  = use_model ? (ent_teclado[pbit] ? pm : 4'h0) : col_drv;

  always #5 clk_sec = ~clk_sec;

  teclado_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(8), .REPEAT_CYC(32)) dut (
    .clk_sec(clk_sec), .rst_n(rst_n), .col(col), .key_ack(key_ack),
    .ent_teclado(ent_teclado), .key_code(key_code), .key_valid(key_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Press until key_valid or timeout; returns cycles waited in n.
  task automatic press_wait(input logic [1:0] row, input logic [3:0] mask);
    use_model = 1'b1;
    pr = row;
    pm = mask;
    n  = 0;
    while (!key_valid && n < 60) begin
      @(negedge clk_sec);
      n++;
    end
    chk("press_valid", {31'd0, key_valid}, 32'd1);
    chk("press_latency_le27", {31'd0, n <= 27}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    press_wait(v.row, v.mask);
    row_ent = one_hot0 >> v.row;
    chk("key_code", {28'd0, key_code}, {28'd0, v.code});
    chk("row_held_valid", {28'd0, ent_teclado}, {28'd0, row_ent});
    repeat (3) @(negedge clk_sec);
    chk("valid_held_pre_ack", {31'd0, key_valid}, 32'd1);
    chk("code_stable", {28'd0, key_code}, {28'd0, v.code});
    key_ack = 1'b1;
    @(negedge clk_sec);
    key_ack = 1'b0;
    chk("valid_clear_after_ack", {31'd0, key_valid}, 32'd0);
    ev = 0;
    repeat (20) begin
      @(negedge clk_sec);
      if (key_valid) ev++;
    end
    chk("no_second_event_held", ev, 0);
    chk("row_held_release", {28'd0, ent_teclado}, {28'd0, row_ent});
    // Release: 2 sync cycles plus 8 low cycles before the row advances.
    use_model = 1'b0;
    repeat (9) @(negedge clk_sec);
    chk("row_held_until_debounced", {28'd0, ent_teclado}, {28'd0, row_ent});
    @(negedge clk_sec);
    row_ent = one_hot0 >> (v.row + 2'd1);
    chk("row_advance_after_release", {28'd0, ent_teclado}, {28'd0, row_ent});
  endtask

  initial begin
    // c counts from col[3]: 0100 -> c=1, 1001 -> col[3] wins (c=0).
    vecs[0] = '{row: 2'd2, mask: 4'b0100, code: 4'h9};
    vecs[1] = '{row: 2'd3, mask: 4'b1001, code: 4'hC};
    vecs[2] = '{row: 2'd0, mask: 4'b0001, code: 4'h3};
    vecs[3] = '{row: 2'd1, mask: 4'b0110, code: 4'h5};
    vecs[4] = '{row: 2'd3, mask: 4'b0001, code: 4'hF};
    vecs[5] = '{row: 2'd0, mask: 4'b1000, code: 4'h0};

    repeat (3) @(negedge clk_sec);
    chk("reset_ent", {28'd0, ent_teclado}, 32'h8);
    chk("reset_code", {28'd0, key_code}, 32'h0);
    chk("reset_valid", {31'd0, key_valid}, 32'd0);

    // Idle scan: each row for 4 cycles starting at row 0, wrapping.
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk_sec);
      row_ent = one_hot0 >> ((k / 4) % 4);
      chk("idle_scan_ent", {28'd0, ent_teclado}, {28'd0, row_ent});
      chk("idle_scan_valid", {31'd0, key_valid}, 32'd0);
    end

    // Stray acknowledge while idle is ignored.
    key_ack = 1'b1;
    @(negedge clk_sec);
    key_ack = 1'b0;
    @(negedge clk_sec);
    chk("stray_ack_valid", {31'd0, key_valid}, 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Bounce: 0010 for 5 cycles at the start of row 1 -> aborted, row 1 rescanned.
    n = 0;
    while (ent_teclado == 4'b0100 && n < 40) begin @(negedge clk_sec); n++; end
    while (ent_teclado != 4'b0100 && n < 40) begin @(negedge clk_sec); n++; end
    chk("bounce_found_row1", {28'd0, ent_teclado}, 32'h4);
    col_drv = 4'b0010;
    ev = 0;
    repeat (5) @(negedge clk_sec);
    col_drv = 4'h0;
    repeat (6) begin
      @(negedge clk_sec);
      if (key_valid) ev++;
    end
    chk("bounce_no_event", ev, 0);
    chk("bounce_rescan_row1", {28'd0, ent_teclado}, 32'h4);
    @(negedge clk_sec);
    chk("bounce_then_row2", {28'd0, ent_teclado}, 32'h2);

    // Held key after ack: one event only, or periodic repeats when enabled.
    press_wait(2'd2, 4'b0001);
    chk("hold_code", {28'd0, key_code}, 32'hB);
    key_ack = 1'b1;
    @(negedge clk_sec);
    key_ack = 1'b0;
    ev = 0;
    repeat (100) begin
      @(negedge clk_sec);
      key_ack = 1'b0;
      if (key_valid) begin
        ev++;
        if (key_code !== 4'hB) ev += 1000;
        key_ack = 1'b1;
      end
    end
    key_ack = 1'b0;
`ifdef TECLADO_REPEAT_EN
    chk("repeat_events_ge2", {31'd0, ev >= 2 && ev < 1000}, 32'd1);
`else
    chk("hold_single_event", ev, 0);
`endif
    use_model = 1'b0;
    repeat (20) @(negedge clk_sec);

    // Reset while an event is pending: cleared asynchronously, not re-reported.
    press_wait(2'd1, 4'b0010);
    chk("pre_reset_code", {28'd0, key_code}, 32'h6);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", {31'd0, key_valid}, 32'd0);
    chk("async_reset_ent", {28'd0, ent_teclado}, 32'h8);
    chk("async_reset_code", {28'd0, key_code}, 32'h0);
    use_model = 1'b0;
    @(negedge clk_sec);
    rst_n = 1'b1;
    ev = 0;
    repeat (60) begin
      @(negedge clk_sec);
      if (key_valid) ev++;
    end
    chk("no_rereport_after_reset", ev, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
